// File: rtl/disp_pkg.sv
// Shared definitions for the multi-channel display selector.
//   CH_IDX_W     : width of a channel index (up to 16 channels)
//   MODE_*       : ctrl[5:4] mode encodings
//   DEFAULT_PAT  : power-on value of every programmable channel
//   scan_state_t : auto-scan FSM states
package disp_pkg;

  localparam int CH_IDX_W = 4;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_ASCII  = 2'b01;
  localparam logic [1:0] MODE_REG    = 2'b10;
  localparam logic [1:0] MODE_SCAN   = 2'b11;

  localparam logic [31:0] DEFAULT_PAT = 32'hAA5555AA;

  typedef enum logic {
    SCAN_IDLE = 1'b0,
    SCAN_RUN  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/disp_scan_timer.sv
// Auto-scan dwell timer. Rotates a channel index through 0..TOTAL-1,
// holding each index for DWELL_CYC cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : scan mode currently selected (held high while scanning)
//   freeze     : hold counter, index and FSM state; suppress advance
//   scan_idx   : channel index to display this cycle
//   scan_adv   : high in the cycle whose edge advances the index
module disp_scan_timer
  import disp_pkg::*;
#(
  parameter int TOTAL     = 10,
  parameter int DWELL_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                freeze,
  output logic [CH_IDX_W-1:0] scan_idx,
  output logic                scan_adv
);

  localparam int CNT_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DWELL_CYC - 1);
  localparam logic [CH_IDX_W-1:0] IDX_LAST = CH_IDX_W'(TOTAL - 1);

  scan_state_t         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_cur;
  logic [CH_IDX_W-1:0] idx_q, idx_d, idx_cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // In IDLE the stored counter/index are stale; the entry cycle therefore
  // behaves as count 0 of channel 0, so every channel (including the first)
  // is shown for exactly DWELL_CYC cycles.
  always_comb begin
    cnt_cur  = (state_q == SCAN_RUN) ? cnt_q : '0;
    idx_cur  = (state_q == SCAN_RUN) ? idx_q : '0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    scan_adv = 1'b0;
    if (!freeze) begin
      if (start) begin
        state_d = SCAN_RUN;
        if (cnt_cur == CNT_LAST) begin
          cnt_d    = '0;
          idx_d    = (idx_cur == IDX_LAST) ? '0 : idx_cur + 1'b1;
          scan_adv = 1'b1;
        end else begin
          cnt_d = cnt_cur + 1'b1;
          idx_d = idx_cur;
        end
      end else begin
        state_d = SCAN_IDLE;
      end
    end
  end

  assign scan_idx = idx_cur;

endmodule

// File: rtl/multi_ch_disp_sel.sv
// Multi-channel 7-segment data selector. Chooses one hex word (CPU-writable
// channel, fixed input channel, register-file word) or an ASCII string for
// the display driver, with an optional auto-scan over all channels.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   wr_en/wr_idx/wr_data : write port for the programmable channels
//   ctrl[5:4]        : mode (direct / ascii / reg / scan); ctrl[3:0] direct select
//   freeze           : hold every display output and the scan state
//   fix_data         : fixed channels, channel k at [k*DATA_W +: DATA_W]
//   reg_data         : register-file word for register display
//   uart_data        : 8 ASCII bytes
//   seg7_data, seg7_ascii_data, ascii_mode, cur_ch : registered display outputs
//   scan_tick        : one-cycle pulse when auto-scan advances
module multi_ch_disp_sel
  import disp_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ASCII_W   = 64,
  parameter int NUM_PROG  = 2,
  parameter int NUM_FIX   = 8,
  parameter int DWELL_CYC = 50_000_000,
  parameter logic [DATA_W-1:0] DEFAULT_PAT = DATA_W'(disp_pkg::DEFAULT_PAT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [((NUM_PROG > 1) ? $clog2(NUM_PROG) : 1)-1:0] wr_idx,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [5:0]          ctrl,
  input  logic                freeze,
  input  logic [((NUM_FIX > 0) ? NUM_FIX*DATA_W : 1)-1:0] fix_data,
  input  logic [DATA_W-1:0]   reg_data,
  input  logic [ASCII_W-1:0]  uart_data,
  output logic [DATA_W-1:0]   seg7_data,
  output logic [ASCII_W-1:0]  seg7_ascii_data,
  output logic                ascii_mode,
  output logic [CH_IDX_W-1:0] cur_ch,
  output logic                scan_tick
);

  localparam int TOTAL    = NUM_PROG + NUM_FIX;
  localparam int WR_IDX_W = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1;

  generate
    if (NUM_PROG < 1 || NUM_FIX < 0 || TOTAL > 16 || DWELL_CYC < 1) begin : g_bad_cfg
      $fatal(1, "multi_ch_disp_sel: illegal NUM_PROG/NUM_FIX/DWELL_CYC");
    end
  endgenerate

  // Programmable channels. Writes are independent of freeze; an index with
  // no matching channel simply matches nothing.
  logic [DATA_W-1:0] prog_q [NUM_PROG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_PROG; k++) prog_q[k] <= DEFAULT_PAT;
    end else begin
      for (int k = 0; k < NUM_PROG; k++) begin
        if (wr_en && (wr_idx == WR_IDX_W'(k))) prog_q[k] <= wr_data;
      end
    end
  end

  logic [1:0] mode;
  assign mode = ctrl[5:4];

  logic [CH_IDX_W-1:0] scan_idx;
  logic                scan_adv;

  disp_scan_timer #(
    .TOTAL     (TOTAL),
    .DWELL_CYC (DWELL_CYC)
  ) u_scan_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (mode == MODE_SCAN),
    .freeze   (freeze),
    .scan_idx (scan_idx),
    .scan_adv (scan_adv)
  );

  // Full 16-entry channel map; unpopulated indices read as zero.
  logic [DATA_W-1:0] ch_tab [16];

  always_comb begin
    for (int k = 0; k < 16; k++) ch_tab[k] = '0;
    for (int k = 0; k < NUM_PROG; k++) ch_tab[k] = prog_q[k];
    for (int k = 0; k < NUM_FIX; k++) ch_tab[NUM_PROG + k] = fix_data[k*DATA_W +: DATA_W];
  end

  logic [DATA_W-1:0]   data_d;
  logic                am_d;
  logic [CH_IDX_W-1:0] ch_d;

  always_comb begin
    data_d = '0;
    am_d   = 1'b0;
    ch_d   = '0;
    case (mode)
      MODE_DIRECT: begin
        ch_d   = ctrl[3:0];
        data_d = ch_tab[ctrl[3:0]];
      end
      MODE_ASCII: am_d = 1'b1;
      MODE_REG:   data_d = reg_data;
      MODE_SCAN: begin
        ch_d   = scan_idx;
        data_d = ch_tab[scan_idx];
      end
      default: ;
    endcase
  end

  // scan_tick follows the timer even when frozen; the timer already
  // suppresses advance under freeze, so it reads 0 then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg7_data       <= '0;
      seg7_ascii_data <= '0;
      ascii_mode      <= 1'b0;
      cur_ch          <= '0;
      scan_tick       <= 1'b0;
    end else begin
      scan_tick <= scan_adv;
      if (!freeze) begin
        seg7_data       <= data_d;
        seg7_ascii_data <= uart_data;
        ascii_mode      <= am_d;
        cur_ch          <= ch_d;
      end
    end
  end

endmodule

// File: tb/tb_multi_ch_disp_sel.sv
module tb_multi_ch_disp_sel;

  localparam int DATA_W   = 32;
  localparam int ASCII_W  = 64;
  localparam int NUM_PROG = 2;
  localparam int NUM_FIX  = 8;
  localparam int DWELL    = 4;
  localparam int TOTAL    = NUM_PROG + NUM_FIX;
  localparam logic [31:0] DEF = 32'hAA5555AA;
  localparam logic [63:0] U   = 64'h48454C4C4F212121;
  localparam logic [63:0] V   = 64'h1122334455667788;
  localparam logic [31:0] R   = 32'hDEADBEEF;

  // ---------------- clock / reset / DUT ----------------
  logic                      clk = 1'b0;
  logic                      rst_n = 1'b1;
  logic                      wr_en = 1'b0;
  logic [0:0]                wr_idx = '0;
  logic [DATA_W-1:0]         wr_data = '0;
  logic [5:0]                ctrl = '0;
  logic                      freeze = 1'b0;
  logic [NUM_FIX*DATA_W-1:0] fix_data;
  logic [DATA_W-1:0]         reg_data = R;
  logic [ASCII_W-1:0]        uart_data = U;
  logic [DATA_W-1:0]         seg7_data;
  logic [ASCII_W-1:0]        seg7_ascii_data;
  logic                      ascii_mode;
  logic [3:0]                cur_ch;
  logic                      scan_tick;

  always #5 clk = ~clk;

  multi_ch_disp_sel #(
    .DATA_W(DATA_W), .ASCII_W(ASCII_W), .NUM_PROG(NUM_PROG),
    .NUM_FIX(NUM_FIX), .DWELL_CYC(DWELL), .DEFAULT_PAT(DEF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .ctrl(ctrl), .freeze(freeze), .fix_data(fix_data), .reg_data(reg_data),
    .uart_data(uart_data), .seg7_data(seg7_data), .seg7_ascii_data(seg7_ascii_data),
    .ascii_mode(ascii_mode), .cur_ch(cur_ch), .scan_tick(scan_tick)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Scan position is derived from the number of unfrozen scan cycles since
  // entry: channel = elapsed / DWELL mod TOTAL.
  logic [31:0] m_prog [NUM_PROG];
  logic [31:0] m_data;
  logic [63:0] m_ascii;
  logic        m_am;
  logic [3:0]  m_ch;
  logic        m_tick;
  int          m_elapsed;

  function automatic logic [31:0] m_lookup(input int sel);
    if (sel < NUM_PROG) return m_prog[sel];
    if (sel < TOTAL)    return fix_data[(sel-NUM_PROG)*DATA_W +: DATA_W];
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_PROG; k++) m_prog[k] = DEF;
    m_data = '0; m_ascii = '0; m_am = 1'b0; m_ch = '0; m_tick = 1'b0; m_elapsed = 0;
  endtask

  task automatic model_edge();
    int ch;
    m_tick = 1'b0;
    if (!freeze) begin
      m_ascii = uart_data;
      m_am    = 1'b0;
      case (ctrl[5:4])
        2'd0: begin m_ch = ctrl[3:0]; m_data = m_lookup(int'(ctrl[3:0])); m_elapsed = 0; end
        2'd1: begin m_am = 1'b1; m_data = '0; m_ch = '0; m_elapsed = 0; end
        2'd2: begin m_data = reg_data; m_ch = '0; m_elapsed = 0; end
        default: begin
          ch     = (m_elapsed / DWELL) % TOTAL;
          m_ch   = 4'(ch);
          m_data = m_lookup(ch);
          m_tick = ((m_elapsed % DWELL) == DWELL - 1);
          m_elapsed++;
        end
      endcase
    end
    if (wr_en && int'(wr_idx) < NUM_PROG) m_prog[wr_idx] = wr_data;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".data"},  64'(seg7_data),       64'(m_data));
    check({tag, ".ascii"}, seg7_ascii_data,      m_ascii);
    check({tag, ".am"},    64'(ascii_mode),      64'(m_am));
    check({tag, ".ch"},    64'(cur_ch),          64'(m_ch));
    check({tag, ".tick"},  64'(scan_tick),       64'(m_tick));
  endtask

  // ---------------- driver ----------------
  // Inputs change at negedge; one step = one active edge, then compare.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".data"},  64'(seg7_data),  64'h0);
    check({tag, ".ascii"}, seg7_ascii_data, 64'h0);
    check({tag, ".am"},    64'(ascii_mode), 64'h0);
    check({tag, ".ch"},    64'(cur_ch),     64'h0);
    check({tag, ".tick"},  64'(scan_tick),  64'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [5:0]  ctrl;
    logic        wr_en;
    logic        wr_idx;
    logic [31:0] wr_data;
    logic        frz;
    logic [63:0] uart;
    logic [31:0] exp_data;
    logic [63:0] exp_ascii;
    logic        exp_am;
    logic [3:0]  exp_ch;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int ticks, wraps, prev_ch, guard, run_left;
    logic [1:0] cur_mode;

    for (int k = 0; k < NUM_FIX; k++)
      fix_data[k*DATA_W +: DATA_W] = 32'hCAFE0000 + 32'(k) * 32'h1111;

    vecs[0]  = '{6'b000000, 1'b0, 1'b0, 32'h0,        1'b0, U, DEF,          U, 1'b0, 4'd0};
    vecs[1]  = '{6'b000001, 1'b1, 1'b1, 32'h12345678, 1'b0, U, DEF,          U, 1'b0, 4'd1};
    vecs[2]  = '{6'b000001, 1'b0, 1'b0, 32'h0,        1'b0, U, 32'h12345678, U, 1'b0, 4'd1};
    vecs[3]  = '{6'b000010, 1'b0, 1'b0, 32'h0,        1'b0, U, 32'hCAFE0000, U, 1'b0, 4'd2};
    vecs[4]  = '{6'b001100, 1'b0, 1'b0, 32'h0,        1'b0, U, 32'h0,        U, 1'b0, 4'd12};
    vecs[5]  = '{6'b001001, 1'b0, 1'b0, 32'h0,        1'b0, U, 32'hCAFE7777, U, 1'b0, 4'd9};
    vecs[6]  = '{6'b001010, 1'b0, 1'b0, 32'h0,        1'b0, U, 32'h0,        U, 1'b0, 4'd10};
    vecs[7]  = '{6'b010000, 1'b0, 1'b0, 32'h0,        1'b0, U, 32'h0,        U, 1'b1, 4'd0};
    vecs[8]  = '{6'b100000, 1'b0, 1'b0, 32'h0,        1'b0, U, R,            U, 1'b0, 4'd0};
    vecs[9]  = '{6'b000000, 1'b1, 1'b0, 32'h0BADF00D, 1'b0, U, DEF,          U, 1'b0, 4'd0};
    vecs[10] = '{6'b000000, 1'b0, 1'b0, 32'h0,        1'b0, U, 32'h0BADF00D, U, 1'b0, 4'd0};
    vecs[11] = '{6'b000001, 1'b1, 1'b1, 32'h55667788, 1'b1, V, 32'h0BADF00D, U, 1'b0, 4'd0};
    vecs[12] = '{6'b010000, 1'b0, 1'b0, 32'h0,        1'b1, V, 32'h0BADF00D, U, 1'b0, 4'd0};
    vecs[13] = '{6'b000001, 1'b0, 1'b0, 32'h0,        1'b0, V, 32'h55667788, V, 1'b0, 4'd1};
    vecs[14] = '{6'b000011, 1'b0, 1'b0, 32'h0,        1'b0, V, 32'hCAFE1111, V, 1'b0, 4'd3};

    // ---- reset ----
    #1 rst_n = 1'b0;
    #2 check_zero("reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table-driven vectors ----
    for (int i = 0; i < 15; i++) begin
      ctrl = vecs[i].ctrl; wr_en = vecs[i].wr_en; wr_idx = vecs[i].wr_idx;
      wr_data = vecs[i].wr_data; freeze = vecs[i].frz; uart_data = vecs[i].uart;
      step($sformatf("vec%0d", i));
      check($sformatf("vec%0d.data", i), 64'(seg7_data), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d.ascii", i), seg7_ascii_data, vecs[i].exp_ascii);
      check($sformatf("vec%0d.am", i), 64'(ascii_mode), 64'(vecs[i].exp_am));
      check($sformatf("vec%0d.ch", i), 64'(cur_ch), 64'(vecs[i].exp_ch));
    end
    wr_en = 1'b0; freeze = 1'b0;

    // ---- auto-scan: 44 cycles, 0..9 then wrap ----
    ctrl = 6'b110000;
    ticks = 0; wraps = 0; prev_ch = -1;
    for (int i = 0; i < 44; i++) begin
      step("scan");
      check("scan.ch_formula", 64'(cur_ch), 64'((i / DWELL) % TOTAL));
      check("scan.tick_formula", 64'(scan_tick), 64'((i % DWELL) == DWELL - 1));
      if (scan_tick) ticks++;
      if (prev_ch == TOTAL - 1 && cur_ch == 4'd0) wraps++;
      prev_ch = int'(cur_ch);
    end
    check("scan.tick_count", 64'(ticks), 64'd11);
    check("scan.wrap_seen", 64'(wraps), 64'd1);

    // ---- freeze mid-dwell ----
    step("pre_frz");
    step("pre_frz");
    freeze = 1'b1;
    ctrl   = 6'b000010;  // mode change while frozen must be ignored
    for (int i = 0; i < 6; i++) begin
      step("frz");
      check("frz.ch_hold", 64'(cur_ch), 64'd1);
      check("frz.no_tick", 64'(scan_tick), 64'd0);
    end
    freeze = 1'b0;
    ctrl   = 6'b110000;
    step("rel");
    check("rel.ch", 64'(cur_ch), 64'd1);
    check("rel.tick0", 64'(scan_tick), 64'd0);
    step("rel");
    check("rel.tick1", 64'(scan_tick), 64'd1);
    step("rel");
    check("rel.ch_next", 64'(cur_ch), 64'd2);

    // ---- reset mid-scan at channel 5 ----
    guard = 0;
    while (cur_ch != 4'd5 && guard < 40) begin
      step("to5");
      guard++;
    end
    check("reach_ch5", 64'(cur_ch), 64'd5);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_async");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_zero("rst_hold");
    #2 rst_n = 1'b1;
    step("post_rst");
    check("post_rst.ch", 64'(cur_ch), 64'd0);
    check("post_rst.data", 64'(seg7_data), 64'(DEF));
    for (int i = 0; i < 3; i++) step("post_rst");
    ctrl = 6'b000001;
    step("post_rst_prog1");
    check("post_rst.prog1", 64'(seg7_data), 64'(DEF));

    // ---- randomized stimulus against the model ----
    run_left = 0;
    cur_mode = 2'd0;
    for (int i = 0; i < 400; i++) begin
      if (run_left == 0) begin
        cur_mode = 2'($urandom_range(0, 3));
        run_left = $urandom_range(1, 25);
      end
      run_left--;
      ctrl      = {cur_mode, 4'($urandom_range(0, 15))};
      wr_en     = ($urandom_range(0, 3) == 0);
      wr_idx    = 1'($urandom_range(0, 1));
      wr_data   = $urandom;
      freeze    = ($urandom_range(0, 7) == 0);
      uart_data = {$urandom, $urandom};
      reg_data  = $urandom;
      if ($urandom_range(0, 9) == 0)
        fix_data[$urandom_range(0, NUM_FIX-1)*DATA_W +: DATA_W] = $urandom;
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
